// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide, behind a valid/ready handshake on both sides.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [SEL_WIDTH-1:0]  opSel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits on ready, and the producer holds data until it.
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [SEL_WIDTH-1:0] OP_ADD   = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] OP_SUB   = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0] OP_AND   = SEL_WIDTH'(2);
  localparam logic [SEL_WIDTH-1:0] OP_OR    = SEL_WIDTH'(3);
  localparam logic [SEL_WIDTH-1:0] OP_SLTU  = SEL_WIDTH'(4);
  localparam logic [SEL_WIDTH-1:0] OP_SLT   = SEL_WIDTH'(5);
  localparam logic [SEL_WIDTH-1:0] OP_XOR   = SEL_WIDTH'(6);
  localparam logic [SEL_WIDTH-1:0] OP_NOR   = SEL_WIDTH'(7);
  localparam logic [SEL_WIDTH-1:0] OP_MUL   = SEL_WIDTH'(8);
  localparam logic [SEL_WIDTH-1:0] OP_MULHU = SEL_WIDTH'(9);
  localparam logic [SEL_WIDTH-1:0] OP_DIVU  = SEL_WIDTH'(10);
  localparam logic [SEL_WIDTH-1:0] OP_REMU  = SEL_WIDTH'(11);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   op_q, op_d;
  logic [W-1:0]           a_q, a_d;      // multiplicand or divisor
  logic [W-1:0]           b_q, b_d;      // multiplier/product-low or dividend/quotient
  logic [W-1:0]           acc_q, acc_d;  // product-high or partial remainder
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic                   zero_q, zero_d;

  logic [W-1:0]           alu_res;
  logic                   in_multi, in_div, op_div;
  logic [W:0]             mul_sum;
  logic [W:0]             div_shift;
  logic [W+1:0]           div_diff;
  logic                   div_ge;
  logic [W-1:0]           acc_step, b_step, final_res;

  always_comb begin
    alu_res = '0;
    case (opSel)
      OP_ADD:  alu_res = operand1 + operand2;
      OP_SUB:  alu_res = operand1 - operand2;
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (operand1 < operand2)};
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      default: alu_res = '0;
    endcase
  end

  assign in_multi = (opSel == OP_MUL) || (opSel == OP_MULHU) ||
                    (opSel == OP_DIVU) || (opSel == OP_REMU);
  assign in_div   = (opSel == OP_DIVU) || (opSel == OP_REMU);
  assign op_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);

  // One iteration of either algorithm; a zero divisor naturally yields
  // an all-ones quotient and the dividend as remainder.
  assign mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign div_shift = {acc_q, b_q[W-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, a_q};
  assign div_ge    = ~|div_diff[W+1:W];

  always_comb begin
    acc_step = mul_sum[W:1];
    b_step   = {mul_sum[0], b_q[W-1:1]};
    if (op_div) begin
      acc_step = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
      b_step   = {b_q[W-2:0], div_ge};
    end
  end

  assign final_res = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? b_step : acc_step;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = opSel;
          cnt_d = '0;
          if (in_multi) begin
            a_d     = in_div ? operand2 : operand1;
            b_d     = in_div ? operand1 : operand2;
            acc_d   = '0;
            state_d = CALC;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        b_d   = b_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d    = '0;
          result_d = final_res;
          zero_d   = (final_res == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases, backpressure,
// mid-operation reset and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;

  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] operand1;
  logic [DW-1:0] operand2;
  logic [SW-1:0] opSel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  alu_multicycle #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .opSel(opSel),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [DW-1:0] ref_alu(input logic [SW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return (a < b) ? DW'(1) : DW'(0);
      4'd5:    return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd8:    return p[DW-1:0];
      4'd9:    return p[2*DW-1:DW];
      4'd10:   return (b == 0) ? {DW{1'b1}} : a / b;
      4'd11:   return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [SW-1:0] op);
    return (op >= 4'd8 && op <= 4'd11) ? DW + 1 : 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [SW-1:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    int n;
    int lat;
    logic saw_ready;
    logic stable;
    logic [DW-1:0] expv;
    logic [DW-1:0] held;
    in_valid = 1'b1;
    opSel    = op;
    operand1 = a;
    operand2 = b;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
    exp_q.push_back(ref_alu(op, a, b));
    tick();
    // scramble inputs after acceptance: they must be ignored from here on
    in_valid = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    opSel    = SW'($urandom_range(0, 15));
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      saw_ready |= in_ready;
      tick();
      lat++;
    end
    expv = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(ref_latency(op)));
    check({tag, "_result"}, {32'd0, result}, {32'd0, expv});
    check({tag, "_zero"}, {63'd0, zero}, {63'd0, (expv == 0)});
    check({tag, "_busy"}, {63'd0, saw_ready | in_ready}, 64'd0);
    held = result;
    stable = 1'b1;
    repeat (hold) begin
      tick();
      if (result !== held || out_valid !== 1'b1) stable = 1'b0;
    end
    check({tag, "_hold"}, {63'd0, stable}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic stable;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [SW-1:0] rop;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    operand1 = '0;
    operand2 = '0;
    opSel = '0;
    repeat (2) tick();
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_zero", {63'd0, zero}, 64'd1);
    rst = 1'b0;
    tick();
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // directed corner cases
    run_op("add_5_7", 4'd0, 32'd5, 32'd7, 0);
    run_op("sub_9_9", 4'd1, 32'd9, 32'd9, 1);
    run_op("slt_m1_1", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu_m1_1", 4'd4, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("nor_m1_1", 4'd7, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("mul_2p16", 4'd8, 32'h0001_0000, 32'h0001_0000, 0);
    run_op("mulhu_2p16", 4'd9, 32'h0001_0000, 32'h0001_0000, 2);
    run_op("divu_100_7", 4'd10, 32'd100, 32'd7, 0);
    run_op("remu_100_7", 4'd11, 32'd100, 32'd7, 0);
    run_op("divu_5_0", 4'd10, 32'd5, 32'd0, 0);
    run_op("remu_5_0", 4'd11, 32'd5, 32'd0, 0);
    run_op("unlisted_13", 4'd13, 32'h1234, 32'h5678, 0);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd2, 0);

    // backpressure while a new op waits on the input
    in_valid = 1'b1;
    opSel = 4'd0;
    operand1 = 32'd5;
    operand2 = 32'd7;
    tick();
    opSel = 4'd1;
    operand1 = 32'd20;
    operand2 = 32'd3;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (result !== 32'd12 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stall", {63'd0, stable}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_idle", {62'd0, in_ready, out_valid}, 64'd2);
    tick();
    in_valid = 1'b0;
    check("bp_new_valid", {63'd0, out_valid}, 64'd1);
    check("bp_new_result", {32'd0, result}, 64'd17);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset during a multiply aborts it
    in_valid = 1'b1;
    opSel = 4'd8;
    operand1 = 32'd3;
    operand2 = 32'd4;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {62'd0, in_ready, out_valid}, 64'd2);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_zero", {63'd0, zero}, 64'd1);
    stable = 1'b1;
    out_ready = 1'b1;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0 || result !== '0) stable = 1'b0;
    end
    out_ready = 1'b0;
    check("abort_no_stale", {63'd0, stable}, 64'd1);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      rop = SW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       ra = '0;
        1:       ra = {DW{1'b1}};
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = DW'($urandom_range(1, 17));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
